// File: rtl/alineador_comas.sv
// K28.5 comma aligner: finds the comma in the sliding 10-bit window, locks symbol phase
// and strobes out one aligned symbol every 10 clocks. `define ALINEADOR_STATS_EN adds lock statistics.
module alineador_comas #(
   parameter logic [9:0]  COMMA_NEG  = 10'b0011111010,
   parameter logic [9:0]  COMMA_POS  = 10'b1100000101,
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic       clk,
   input  logic       reinicio,
   input  logic [9:0] parallel_in,
   output logic [9:0] symbol_out,
   output logic       symbol_valid,
   output logic       is_comma,
   output logic       aligned
`ifdef ALINEADOR_STATS_EN
   ,
   output logic [7:0] realign_count,
   output logic       lock_event
`endif
);

   typedef enum logic [1:0] {SEARCH, CHECK, SYNC} state_t;

   localparam logic [3:0] LOCK_C = LOCK_COUNT[3:0];
   localparam logic [3:0] LOSS_C = LOSS_COUNT[3:0];

   state_t     state_q;
   logic [3:0] phase_q;
   logic [3:0] phase_d;
   logic [3:0] good_q;
   logic [3:0] bad_q;
   logic [9:0] symbol_q;
   logic       valid_q;
   logic       comma_q;
   logic       aligned_q;
   logic       match;
   logic       atPhase0;

`ifdef ALINEADOR_STATS_EN
   logic [7:0] realignCnt_q;
   logic       lockEvent_q;
`endif

   assign match    = (parallel_in == COMMA_NEG) || (parallel_in == COMMA_POS);
   assign atPhase0 = (phase_q == 4'd0);
   assign phase_d  = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;

   // phase_q is the phase of the sample currently on parallel_in; a realign makes
   // the matching sample phase 0, so the register is loaded with 1 for the next one.
   always_ff @(posedge clk or posedge reinicio) begin
      if (reinicio) begin
         state_q   <= SEARCH;
         phase_q   <= 4'd0;
         good_q    <= 4'd0;
         bad_q     <= 4'd0;
         symbol_q  <= 10'b0;
         valid_q   <= 1'b0;
         comma_q   <= 1'b0;
         aligned_q <= 1'b0;
`ifdef ALINEADOR_STATS_EN
         realignCnt_q <= 8'h00;
         lockEvent_q  <= 1'b0;
`endif
      end else begin
         phase_q <= phase_d;
         valid_q <= 1'b0;
`ifdef ALINEADOR_STATS_EN
         lockEvent_q <= 1'b0;
`endif
         case (state_q)
            SEARCH: begin
               aligned_q <= 1'b0;
               if (match) begin
                  phase_q <= 4'd1;
                  good_q  <= 4'd1;
                  if (LOCK_C <= 4'd1) begin
                     state_q   <= SYNC;
                     bad_q     <= 4'd0;
                     symbol_q  <= parallel_in;
                     comma_q   <= 1'b1;
                     valid_q   <= 1'b1;
                     aligned_q <= 1'b1;
`ifdef ALINEADOR_STATS_EN
                     lockEvent_q <= 1'b1;
`endif
                  end else begin
                     state_q <= CHECK;
                  end
               end
            end

            CHECK: begin
               aligned_q <= 1'b0;
               if (atPhase0) begin
                  if (match) begin
                     if (good_q + 4'd1 >= LOCK_C) begin
                        state_q   <= SYNC;
                        good_q    <= LOCK_C;
                        bad_q     <= 4'd0;
                        symbol_q  <= parallel_in;
                        comma_q   <= 1'b1;
                        valid_q   <= 1'b1;
                        aligned_q <= 1'b1;
`ifdef ALINEADOR_STATS_EN
                        lockEvent_q <= 1'b1;
`endif
                     end else begin
                        good_q <= good_q + 4'd1;
                     end
                  end else begin
                     state_q <= SEARCH;
                     good_q  <= 4'd0;
                  end
               end else if (match) begin
                  phase_q <= 4'd1;
                  good_q  <= 4'd1;
               end
            end

            SYNC: begin
               aligned_q <= 1'b1;
               if (atPhase0) begin
                  symbol_q <= parallel_in;
                  comma_q  <= match;
                  valid_q  <= 1'b1;
                  if (match) begin
                     bad_q <= 4'd0;
                  end
               end else if (match) begin
                  // A misplaced comma that ends lock is not used to realign.
                  if (bad_q + 4'd1 >= LOSS_C) begin
                     state_q   <= SEARCH;
                     bad_q     <= 4'd0;
                     good_q    <= 4'd0;
                     aligned_q <= 1'b0;
`ifdef ALINEADOR_STATS_EN
                     if (realignCnt_q != 8'hFF) begin
                        realignCnt_q <= realignCnt_q + 8'd1;
                     end
`endif
                  end else begin
                     bad_q <= bad_q + 4'd1;
                  end
               end
            end

            default: begin
               state_q   <= SEARCH;
               aligned_q <= 1'b0;
            end
         endcase
      end
   end

   assign symbol_out   = symbol_q;
   assign symbol_valid = valid_q;
   assign is_comma     = comma_q;
   assign aligned      = aligned_q;

`ifdef ALINEADOR_STATS_EN
   assign realign_count = realignCnt_q;
   assign lock_event    = lockEvent_q;
`endif

endmodule

// File: tb/tb_alineador_comas.sv
// Bench for alineador_comas: table of comma schedules with expected alignment windows,
// strobe expectations queued at drive time and consumed when the DUT strobes.
module tb_alineador_comas;

   localparam logic [9:0] KNEG = 10'b0011111010;
   localparam logic [9:0] KPOS = 10'b1100000101;

   logic       clk = 1'b0;
   logic       reinicio;
   logic [9:0] parallel_in;
   logic [9:0] symbol_out;
   logic       symbol_valid;
   logic       is_comma;
   logic       aligned;
`ifdef ALINEADOR_STATS_EN
   logic [7:0] realign_count;
   logic       lock_event;
`endif

   alineador_comas dut (
      .clk          (clk),
      .reinicio     (reinicio),
      .parallel_in  (parallel_in),
      .symbol_out   (symbol_out),
      .symbol_valid (symbol_valid),
      .is_comma     (is_comma),
      .aligned      (aligned)
`ifdef ALINEADOR_STATS_EN
      ,
      .realign_count(realign_count),
      .lock_event   (lock_event)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [9:0] sym;
      logic       comma;
   } exp_t;

   typedef struct {
      string name;
      int    commaCyc[8];
      int    posMask;
      int    runLen;
      int    alignRise;
      int    alignFall;
      int    firstStrobe;
      int    lastStrobe;
      int    expRealign;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   tests    = 0;
   int   failures = 0;

   // Random filler that is never a comma in either disparity.
   function automatic logic [9:0] filler();
      logic [9:0] w;
      do begin
         w = 10'($urandom_range(0, 1023));
      end while (w == KNEG || w == KPOS);
      return w;
   endfunction

   function automatic logic [9:0] windowFor(input vec_t v, input int c);
      for (int k = 0; k < 8; k++) begin
         if (v.commaCyc[k] == c) begin
            return v.posMask[k] ? KPOS : KNEG;
         end
      end
      return filler();
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Runs one table entry from a fresh reset; observation cycle = sample cycle + 1.
   task automatic applyStimulus(input int idx);
      vec_t       v;
      exp_t       e;
      logic [9:0] w;
      int         obs;
      logic       expValid;
      logic       expAl;
      v = vecs[idx];
      sb.delete();
      reinicio    = 1'b1;
      parallel_in = 10'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput($sformatf("%s reset aligned", v.name), 32'(aligned), 32'd0);
      checkOutput($sformatf("%s reset valid", v.name), 32'(symbol_valid), 32'd0);
      checkOutput($sformatf("%s reset symbol", v.name), 32'(symbol_out), 32'd0);
      @(negedge clk);
      reinicio = 1'b0;
      for (int c = 0; c < v.runLen; c++) begin
         w           = windowFor(v, c);
         parallel_in = w;
         obs         = c + 1;
         if (v.firstStrobe >= 0 && obs >= v.firstStrobe && obs <= v.lastStrobe &&
             ((obs - v.firstStrobe) % 10) == 0) begin
            e.cyc   = obs;
            e.sym   = w;
            e.comma = (w == KNEG) || (w == KPOS);
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         expAl = (v.alignRise >= 0) && (obs >= v.alignRise) && (v.alignFall < 0 || obs < v.alignFall);
         checkOutput($sformatf("%s aligned@%0d", v.name, obs), 32'(aligned), 32'(expAl));
         expValid = (sb.size() > 0) && (sb[0].cyc == obs);
         checkOutput($sformatf("%s strobe@%0d", v.name, obs), 32'(symbol_valid), 32'(expValid));
         if (expValid) begin
            e = sb.pop_front();
            if (symbol_valid) begin
               checkOutput($sformatf("%s symbol@%0d", v.name, obs), 32'(symbol_out), 32'(e.sym));
               checkOutput($sformatf("%s is_comma@%0d", v.name, obs), 32'(is_comma), 32'(e.comma));
            end
         end
`ifdef ALINEADOR_STATS_EN
         checkOutput($sformatf("%s lock_event@%0d", v.name, obs), 32'(lock_event),
                     32'(obs == v.alignRise));
`endif
      end
`ifdef ALINEADOR_STATS_EN
      checkOutput($sformatf("%s realign_count", v.name), 32'(realign_count), 32'(v.expRealign));
`endif
   endtask

   initial begin
      reinicio    = 1'b1;
      parallel_in = 10'b0;

      vecs[0] = '{"lock",       '{100, 110, 120, -1, -1, -1, -1, -1}, 0, 160, 121, -1, 121, 151, 0};
      vecs[1] = '{"broken",     '{100, 110, -1, -1, -1, -1, -1, -1},  0, 160, -1,  -1, -1,  -1,  0};
      vecs[2] = '{"phasejump",  '{100, 113, 123, 133, -1, -1, -1, -1}, 0, 170, 134, -1, 134, 164, 0};
      vecs[3] = '{"loss",       '{200, 210, 220, 235, 245, 255, 265, -1}, 0, 300, 221, 266, 221, 261, 1};
      vecs[4] = '{"lossreset",  '{200, 210, 220, 235, 245, 255, 260, 275}, 0, 300, 221, -1, 221, 291, 0};
      vecs[5] = '{"mixeddisp",  '{50, 60, 70, 80, -1, -1, -1, -1},   32'b1010, 100, 71, -1, 71, 91, 0};

      for (int i = 0; i < 6; i++) begin
         applyStimulus(i);
      end

      // Mid-SYNC asynchronous reset, landing while a strobe is being presented.
      applyStimulus(0);
      parallel_in = filler();
      @(posedge clk);
      #1;
      checkOutput("midreset valid before", 32'(symbol_valid), 32'd1);
      checkOutput("midreset aligned before", 32'(aligned), 32'd1);
      #2;
      reinicio = 1'b1;
      #1;
      checkOutput("midreset valid", 32'(symbol_valid), 32'd0);
      checkOutput("midreset aligned", 32'(aligned), 32'd0);
      checkOutput("midreset symbol", 32'(symbol_out), 32'd0);
      checkOutput("midreset is_comma", 32'(is_comma), 32'd0);

      // After release a single comma only enters CHECK; lock needs the full run again.
      @(negedge clk);
      reinicio = 1'b0;
      for (int c = 0; c < 25; c++) begin
         parallel_in = (c == 5 || c == 15) ? KNEG : filler();
         @(posedge clk);
         #1;
         checkOutput($sformatf("postreset aligned@%0d", c + 1), 32'(aligned), 32'd0);
         checkOutput($sformatf("postreset strobe@%0d", c + 1), 32'(symbol_valid), 32'd0);
      end
      parallel_in = KNEG;
      @(posedge clk);
      #1;
      checkOutput("postreset lock aligned", 32'(aligned), 32'd1);
      checkOutput("postreset lock strobe", 32'(symbol_valid), 32'd1);
      checkOutput("postreset lock symbol", 32'(symbol_out), 32'(KNEG));

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
